// File: rtl/seq_alu_if.sv
// Operand/result bundle between the CPU control unit (master) and seq_alu (slave).
// Signal names follow the datapath schematic: A/B operand latches, Z result register.
interface seq_alu_if #(
  parameter int WIDTH = 32
);
  logic                 start;
  logic [4:0]           opcode;
  logic [WIDTH-1:0]     A;
  logic [WIDTH-1:0]     B;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   Z;
  logic                 zero;
  logic                 dbz;

  modport master (output start, opcode, A, B, input busy, done, Z, zero, dbz);
  modport slave  (input start, opcode, A, B, output busy, done, Z, zero, dbz);
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops, iterative signed MUL/DIV
// on magnitudes with a final sign-correction cycle; all outputs registered.
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic       clock,
  input  logic       clear,
  seq_alu_if.slave   bus
);

  typedef enum logic [4:0] {
    OP_ADD  = 5'b00011, OP_SUB = 5'b00100, OP_SHR = 5'b00101, OP_SHRA = 5'b00110,
    OP_SHL  = 5'b00111, OP_ROR = 5'b01000, OP_ROL = 5'b01001, OP_AND  = 5'b01010,
    OP_OR   = 5'b01011, OP_MUL = 5'b01111, OP_DIV = 5'b10000, OP_NEG  = 5'b10001,
    OP_NOT  = 5'b10010
  } op_e;

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX, S_DONE} state_e;

  state_e               state_q;
  logic [SHW-1:0]       cnt_q;
  logic [WIDTH-1:0]     hi_q, lo_q, mcand_q;
  logic                 is_div_q, sa_q, sb_q;
  logic                 busy_q, done_q, zero_q, dbz_q;
  logic [2*WIDTH-1:0]   z_q;

  logic [SHW-1:0]       n;
  logic [WIDTH-1:0]     sc_lo;
  logic [2*WIDTH-1:0]   sc_z;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       mul_sum, div_shifted, div_trial;
  logic [WIDTH-1:0]     hi_d, lo_d;
  logic [2*WIDTH-1:0]   prod, fix_z;
  logic [WIDTH-1:0]     quo_s, rem_s;

  // Single-cycle results straight from the live operands.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    n     = bus.B[SHW-1:0];
    sc_lo = '0;
    case (bus.opcode)
      OP_AND:  sc_lo = bus.A & bus.B;
      OP_OR:   sc_lo = bus.A | bus.B;
      OP_ADD:  sc_lo = bus.A + bus.B;
      OP_SUB:  sc_lo = bus.A - bus.B;
      OP_SHR:  sc_lo = bus.A >> n;
      OP_SHRA: sc_lo = $unsigned($signed(bus.A) >>> n);
      OP_SHL:  sc_lo = bus.A << n;
      OP_ROR:  sc_lo = (bus.A >> n) | (bus.A << (WIDTH - int'(n)));
      OP_ROL:  sc_lo = (bus.A << n) | (bus.A >> (WIDTH - int'(n)));
      OP_NEG:  sc_lo = -bus.B;
      OP_NOT:  sc_lo = ~bus.B;
      default: sc_lo = '0;
    endcase
    sc_z  = {{WIDTH{1'b0}}, sc_lo};
    a_mag = bus.A[WIDTH-1] ? -bus.A : bus.A;
    b_mag = bus.B[WIDTH-1] ? -bus.B : bus.B;
  end

  // One iteration step: MUL shifts {hi,lo} right after a conditional add,
  // DIV shifts the dividend into the remainder and keeps the trial if non-negative.
  always_comb begin
    mul_sum     = {1'b0, hi_q} + {1'b0, {WIDTH{lo_q[0]}} & mcand_q};
    div_shifted = {hi_q, lo_q[WIDTH-1]};
    div_trial   = div_shifted - {1'b0, mcand_q};
    if (is_div_q) begin
      hi_d = div_trial[WIDTH] ? div_shifted[WIDTH-1:0] : div_trial[WIDTH-1:0];
      lo_d = {lo_q[WIDTH-2:0], ~div_trial[WIDTH]};
    end else begin
      hi_d = mul_sum[WIDTH:1];
      lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
    prod  = {hi_q, lo_q};
    quo_s = (sa_q ^ sb_q) ? -lo_q : lo_q;
    rem_s = sa_q ? -hi_q : hi_q;
    fix_z = is_div_q ? {rem_s, quo_s} : ((sa_q ^ sb_q) ? -prod : prod);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      mcand_q  <= '0;
      is_div_q <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      z_q      <= '0;
      zero_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            if (bus.opcode == OP_DIV && bus.B == '0) begin
              z_q     <= {bus.A, {WIDTH{1'b1}}};
              zero_q  <= 1'b0;
              dbz_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else if (bus.opcode == OP_MUL || bus.opcode == OP_DIV) begin
              hi_q     <= '0;
              lo_q     <= a_mag;
              mcand_q  <= b_mag;
              sa_q     <= bus.A[WIDTH-1];
              sb_q     <= bus.B[WIDTH-1];
              is_div_q <= (bus.opcode == OP_DIV);
              cnt_q    <= SHW'(WIDTH - 1);
              busy_q   <= 1'b1;
              state_q  <= S_ITER;
            end else begin
              z_q     <= sc_z;
              zero_q  <= (sc_z == '0);
              dbz_q   <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end
        end
        S_ITER: begin
          hi_q <= hi_d;
          lo_q <= lo_d;
          if (cnt_q == '0) begin
            busy_q  <= 1'b0;
            state_q <= S_FIX;
          end else begin
            cnt_q <= cnt_q - SHW'(1);
          end
        end
        S_FIX: begin
          z_q     <= fix_z;
          zero_q  <= (fix_z == '0);
          dbz_q   <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
        default: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.Z    = z_q;
  assign bus.zero = zero_q;
  assign bus.dbz  = dbz_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed-vector bench for seq_alu (WIDTH=32): reset, single-cycle ops,
// shifts/rotates, MUL/DIV latency and results, handshake and mid-op clear.
module tb_seq_alu;

  localparam int W = 32;

  localparam logic [4:0] ADD = 5'b00011, SUB = 5'b00100, SHR = 5'b00101, SHRA = 5'b00110,
                         SHL = 5'b00111, ROR = 5'b01000, ROL = 5'b01001, AND_ = 5'b01010,
                         OR_ = 5'b01011, MUL = 5'b01111, DIV = 5'b10000, NEG = 5'b10001,
                         NOT_ = 5'b10010, BAD = 5'b11111;

  logic clock;
  logic clear;
  int   checks;
  int   errors;

  seq_alu_if #(.WIDTH(W)) bus ();

  seq_alu #(.WIDTH(W)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drive a request at the negedge once the DUT is free; returns #1 after the accepting edge.
  task automatic issue(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clock);
    for (int g = 0; g < 100 && (bus.busy || bus.done); g++) @(negedge clock);
    bus.start  = 1'b1;
    bus.opcode = op;
    bus.A      = a;
    bus.B      = b;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
  endtask

  // Edges after the accepting edge until done is seen, and busy samples before it.
  task automatic wait_done(output int lat, output int bcnt, output bit hit, output bit overlap);
    lat = 0; bcnt = 0; hit = 1'b0; overlap = 1'b0;
    for (int i = 0; i <= 60; i++) begin
      if (bus.done && bus.busy) overlap = 1'b1;
      if (bus.done) begin
        hit = 1'b1;
        lat = i;
        break;
      end
      if (bus.busy) bcnt++;
      @(posedge clock);
      #1;
    end
  endtask

  task automatic test_reset();
    clear = 1'b1;
    bus.start = 1'b1; bus.opcode = ADD; bus.A = 32'd1; bus.B = 32'd2;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.zero, bus.dbz} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b expected 0000", {bus.busy, bus.done, bus.zero, bus.dbz});
    end
    checks++;
    if (bus.Z !== 64'd0) begin
      errors++; $display("FAIL reset_z: got %h expected 0", bus.Z);
    end
    @(negedge clock);
    clear = 1'b0; bus.start = 1'b0;
    @(posedge clock); #1;
    checks++;
    if (bus.done !== 1'b0) begin
      errors++; $display("FAIL reset_start_dropped: done got %b expected 0", bus.done);
    end
  endtask

  task automatic test_single();
    int lat, bc; bit hit, ov;
    issue(ADD, 32'h7FFF_FFFF, 32'd1);
    wait_done(lat, bc, hit, ov);
    checks++;
    if (!hit || lat != 0) begin
      errors++; $display("FAIL add_latency: got %0d (hit %b) expected 0", lat, hit);
    end
    checks++;
    if (bus.Z !== 64'h0000_0000_8000_0000 || bus.zero !== 1'b0) begin
      errors++; $display("FAIL add_result: got %h zero %b expected 0000000080000000 zero 0", bus.Z, bus.zero);
    end
    issue(SUB, 32'd5, 32'd5);
    wait_done(lat, bc, hit, ov);
    checks++;
    if (bus.Z !== 64'd0 || bus.zero !== 1'b1) begin
      errors++; $display("FAIL sub_zero: got %h zero %b expected 0 zero 1", bus.Z, bus.zero);
    end
    issue(AND_, 32'hF0F0_1234, 32'h0FF0_FF00);
    wait_done(lat, bc, hit, ov);
    checks++;
    if (bus.Z !== 64'h0000_0000_00F0_1200) begin
      errors++; $display("FAIL and: got %h expected 00000000_00F01200", bus.Z);
    end
    issue(OR_, 32'hF000_0001, 32'h0000_0F00);
    wait_done(lat, bc, hit, ov);
    checks++;
    if (bus.Z !== 64'h0000_0000_F000_0F01) begin
      errors++; $display("FAIL or: got %h expected 00000000_F0000F01", bus.Z);
    end
    issue(NEG, 32'h1234_5678, 32'd1);
    wait_done(lat, bc, hit, ov);
    checks++;
    if (bus.Z !== 64'h0000_0000_FFFF_FFFF) begin
      errors++; $display("FAIL neg: got %h expected 00000000_FFFFFFFF", bus.Z);
    end
    issue(NOT_, 32'd0, 32'h0000_00FF);
    wait_done(lat, bc, hit, ov);
    checks++;
    if (bus.Z !== 64'h0000_0000_FFFF_FF00) begin
      errors++; $display("FAIL not: got %h expected 00000000_FFFFFF00", bus.Z);
    end
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (bus.Z !== 64'h0000_0000_FFFF_FF00 || bus.done !== 1'b0) begin
      errors++; $display("FAIL hold_after_done: got %h done %b expected 00000000_FFFFFF00 done 0", bus.Z, bus.done);
    end
  endtask

  task automatic test_shift();
    int lat, bc; bit hit, ov;
    logic [W-1:0] av [6] = '{32'h8000_0000, 32'h8000_0001, 32'h0000_0001, 32'h1234_5678, 32'h8000_0000, 32'h0000_0001};
    logic [W-1:0] bv [6] = '{32'd4,         32'd1,         32'h21,        32'h0000_0000, 32'd31,        32'hFFFF_FFE1};
    logic [4:0]   ov_[6] = '{SHRA,          ROL,           SHL,           ROR,           SHR,           ROR};
    logic [W-1:0] ev [6] = '{32'hF800_0000, 32'h0000_0003, 32'h0000_0002, 32'h1234_5678, 32'h0000_0001, 32'h8000_0000};
    for (int i = 0; i < 6; i++) begin
      issue(ov_[i], av[i], bv[i]);
      wait_done(lat, bc, hit, ov);
      checks++;
      if (!hit || bus.Z !== {32'd0, ev[i]}) begin
        errors++; $display("FAIL shift_vec%0d: got %h expected %h", i, bus.Z, {32'd0, ev[i]});
      end
    end
  endtask

  task automatic test_mul();
    int lat, bc; bit hit, ov;
    issue(MUL, -32'sd3, 32'sd7);
    wait_done(lat, bc, hit, ov);
    checks++;
    if (!hit || lat != 33) begin
      errors++; $display("FAIL mul_latency: got %0d (hit %b) expected 33", lat, hit);
    end
    checks++;
    if (bc != 32 || ov) begin
      errors++; $display("FAIL mul_busy: got %0d cycles overlap %b expected 32 overlap 0", bc, ov);
    end
    checks++;
    if (bus.Z !== 64'hFFFF_FFFF_FFFF_FFEB) begin
      errors++; $display("FAIL mul_neg: got %h expected FFFFFFFF_FFFFFFEB", bus.Z);
    end
    issue(MUL, 32'h8000_0000, 32'h8000_0000);
    wait_done(lat, bc, hit, ov);
    checks++;
    if (bus.Z !== 64'h4000_0000_0000_0000) begin
      errors++; $display("FAIL mul_minmin: got %h expected 40000000_00000000", bus.Z);
    end
    issue(MUL, -32'sd5, -32'sd6);
    wait_done(lat, bc, hit, ov);
    checks++;
    if (bus.Z !== 64'd30) begin
      errors++; $display("FAIL mul_negneg: got %h expected 30", bus.Z);
    end
  endtask

  task automatic test_div();
    int lat, bc; bit hit, ov;
    issue(DIV, -32'sd7, 32'sd2);
    wait_done(lat, bc, hit, ov);
    checks++;
    if (!hit || lat != 33 || bus.Z !== 64'hFFFF_FFFF_FFFF_FFFD || bus.dbz !== 1'b0) begin
      errors++; $display("FAIL div_neg: got %h lat %0d dbz %b expected FFFFFFFF_FFFFFFFD lat 33 dbz 0", bus.Z, lat, bus.dbz);
    end
    issue(DIV, 32'sd7, -32'sd2);
    wait_done(lat, bc, hit, ov);
    checks++;
    if (bus.Z !== 64'h0000_0001_FFFF_FFFD) begin
      errors++; $display("FAIL div_negb: got %h expected 00000001_FFFFFFFD", bus.Z);
    end
    issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(lat, bc, hit, ov);
    checks++;
    if (bus.Z !== 64'h0000_0000_8000_0000) begin
      errors++; $display("FAIL div_overflow: got %h expected 00000000_80000000", bus.Z);
    end
    issue(DIV, 32'd9, 32'd0);
    wait_done(lat, bc, hit, ov);
    checks++;
    if (!hit || lat != 0 || bus.Z !== 64'h0000_0009_FFFF_FFFF || bus.dbz !== 1'b1) begin
      errors++; $display("FAIL div_by_zero: got %h lat %0d dbz %b expected 00000009_FFFFFFFF lat 0 dbz 1", bus.Z, lat, bus.dbz);
    end
    issue(BAD, 32'd3, 32'd4);
    wait_done(lat, bc, hit, ov);
    checks++;
    if (!hit || bus.Z !== 64'd0 || bus.zero !== 1'b1 || bus.dbz !== 1'b0) begin
      errors++; $display("FAIL unknown_op: got %h zero %b dbz %b expected 0 zero 1 dbz 0", bus.Z, bus.zero, bus.dbz);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc; bit hit, ov;
    int extra;
    issue(ADD, 32'd10, 32'd20);
    // Start held across the DONE edge must be ignored, not queued.
    @(negedge clock);
    bus.start = 1'b1; bus.opcode = SUB; bus.A = 32'd1; bus.B = 32'd9;
    @(posedge clock); #1;
    bus.start = 1'b0;
    extra = 0;
    repeat (4) begin
      @(posedge clock); #1;
      if (bus.done) extra++;
    end
    checks++;
    if (extra != 0 || bus.Z !== 64'd30) begin
      errors++; $display("FAIL start_in_done: extra dones %0d Z %h expected 0 and 30", extra, bus.Z);
    end
    issue(ADD, 32'd1, 32'd1);
    wait_done(lat, bc, hit, ov);
    checks++;
    if (!hit || bus.Z !== 64'd2) begin
      errors++; $display("FAIL b2b_next: got %h expected 2", bus.Z);
    end
  endtask

  task automatic test_handshake();
    int lat; bit hit;
    issue(MUL, 32'd100, 32'd200);
    lat = 0; hit = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      if (i == 5) begin
        @(negedge clock);
        bus.start = 1'b1; bus.opcode = ADD; bus.A = 32'hDEAD_BEEF; bus.B = 32'h1234_5678;
      end
      @(posedge clock); #1;
      bus.start = 1'b0;
      if (bus.done) begin
        hit = 1'b1; lat = i;
        break;
      end
    end
    checks++;
    if (!hit || lat != 33 || bus.Z !== 64'd20000) begin
      errors++; $display("FAIL start_while_busy: got %h lat %0d expected 20000 lat 33", bus.Z, lat);
    end
  endtask

  task automatic test_clear_mid();
    int lat, bc; bit hit, ov;
    int seen;
    issue(DIV, 32'd100, 32'd7);
    repeat (10) @(posedge clock);
    @(negedge clock);
    clear = 1'b1;
    @(posedge clock); #1;
    checks++;
    if ({bus.busy, bus.done, bus.zero, bus.dbz} !== 4'b0000 || bus.Z !== 64'd0) begin
      errors++; $display("FAIL clear_mid: flags %b Z %h expected 0000 and 0", {bus.busy, bus.done, bus.zero, bus.dbz}, bus.Z);
    end
    @(negedge clock);
    clear = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clock); #1;
      if (bus.done || bus.busy) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL clear_abandon: activity cycles %0d expected 0", seen);
    end
    issue(MUL, 32'd6, 32'd7);
    wait_done(lat, bc, hit, ov);
    checks++;
    if (!hit || lat != 33 || bus.Z !== 64'd42) begin
      errors++; $display("FAIL mul_after_clear: got %h lat %0d expected 42 lat 33", bus.Z, lat);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clear = 1'b1;
    bus.start = 1'b0; bus.opcode = 5'd0; bus.A = '0; bus.B = '0;
    test_reset();
    test_single();
    test_shift();
    test_mul();
    test_div();
    test_back_to_back();
    test_handshake();
    test_clear_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, multi-cycle successor to the datapath ALU. It registers operands on a start/done handshake and completes logic, add/sub, shift, rotate, negate and not in one cycle. It runs signed multiply and signed divide as iterative WIDTH-cycle engines, and reports divide-by-zero and zero-result status. It sits between the register-file operand latches (A, B) and the Z register (LO/HI split) of the CPU datapath. The control unit drives `start` and waits on `done`.

## Interface
- `WIDTH`, default 32: operand width. Must be a power of two, ≥ 8.
- `SHW`, default $clog2(WIDTH): width of the shift-amount field taken from B.
- `clock`  in  1  rising-edge clock.
- `clear`  in  1  synchronous, active-high reset.
- `start`  in  1  request. Sampled only when `busy`=0.
- `opcode`  in  5  operation. Encodings: AND 01010, OR 01011, ADD 00011, SUB 00100, MUL 01111, DIV 10000, SHR 00101, SHRA 00110, SHL 00111, ROR 01000, ROL 01001, NEG 10001, NOT 10010.
- `A`, `B`  in  WIDTH  operands. Captured on the accepted-start edge.
- `busy`  out  1  high while a MUL/DIV iteration is in progress.
- `done`  out  1  one-cycle pulse: `Z` and flags are valid.
- `Z`  out  2*WIDTH  result. Z[WIDTH-1:0] is LO, Z[2*WIDTH-1:WIDTH] is HI.
- `zero`  out  1  Z == 0, updated with `done`.
- `dbz`  out  1  last DIV had B == 0, updated with `done`.

## Operation
- FSM states:
  - IDLE: accept start.
  - ITER: MUL/DIV loop, counter counts WIDTH-1 down to 0.
  - DONE: one cycle, `done`=1, then IDLE.
- IDLE + start + single-cycle opcode: compute from `A`/`B`, register the result into Z, go to DONE.
- IDLE + start + MUL/DIV: latch |A| and |B| and the sign bits, clear the accumulator, go to ITER.
- IDLE + start + B==0 + DIV: no iteration. Go to DONE with Z = {A, all-ones}, `dbz`=1.
- Single-cycle op results: HI = 0; LO = result.
  - ADD/SUB: modulo 2^WIDTH, carries dropped.
  - NEG: two's complement of B.
  - NOT: ~B.
- Shifts and rotates use amount n = B[SHW-1:0]. Upper bits of B are ignored.
  - SHR/SHL: logical.
  - SHRA: fills with A[WIDTH-1].
  - ROR/ROL: rotate A by n. n=0 returns A.
- MUL: signed × signed, full 2*WIDTH product in Z.
  - Radix-2 shift-add on magnitudes, one bit per cycle.
  - Product is negated at the end if the sign bits differ.
- DIV: signed restoring division on magnitudes, one bit per cycle.
  - LO = quotient, truncated toward zero, sign = sA^sB.
  - HI = remainder, sign = sA.
  - −2^(WIDTH-1) / −1 gives LO = −2^(WIDTH-1) (wraps), HI = 0.
- Unknown opcode: DONE with Z = 0, `zero`=1, `dbz`=0.
- `start` while `busy` or in DONE: ignored and not queued.
- Operand or opcode changes after acceptance have no effect.
- Z, `zero` and `dbz` hold their values until the next `done`.
- `clear` (any state, including mid-ITER): next edge gives IDLE, `busy`=0, `done`=0, Z=0, `zero`=0, `dbz`=0. Any in-flight operation is abandoned.
- `clear` and `start` in the same cycle: `clear` wins and `start` is dropped.

## Timing
- Single-cycle op: start accepted at edge k; `done`=1 and Z valid in the cycle after edge k. Next start can be accepted at edge k+2.
- MUL/DIV: start accepted at edge k.
  - `busy`=1 from after edge k through after edge k+WIDTH-1.
  - ITER occupies WIDTH cycles.
  - DONE (`done`=1, Z valid) follows edge k+WIDTH+1 and lasts one cycle.
  - Total latency is WIDTH+1 edges (33 for WIDTH=32).
- DIV by zero: same latency as a single-cycle op.
- `done` and `busy` are never high together.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset then single-cycle ops (WIDTH=32):
  - Apply `clear`: all outputs read 0.
  - ADD A=0x7FFFFFFF, B=1 → Z=0x0000_0000_8000_0000, `done` one edge after start.
  - SUB 5−5 → Z=0, `zero`=1.
- Shift and rotate:
  - SHRA A=0x80000000, B=4 → LO=0xF8000000.
  - ROL A=0x80000001, B=1 → 0x00000003.
  - SHL with B=0x21 → shift by 1.
  - ROR with n=0 → A.
- MUL: −3 × 7 → Z=0xFFFFFFFF_FFFFFFEB; `done` exactly 33 edges after start; `busy` high for 32 cycles.
- DIV:
  - −7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - 0x80000000 / −1 → LO=0x80000000, HI=0.
  - 9 / 0 → `dbz`=1, Z={0x00000009, 0xFFFFFFFF}, `done` one edge after start.
- Handshake: pulse `start` with ADD mid-MUL → ignored; MUL result unchanged. Change A/B during ITER → result unaffected.
- Reset mid-operation: assert `clear` 10 cycles into DIV → IDLE, Z=0, no `done`. A new MUL 6×7 then completes with Z=42.
